// File: rtl/mux_bist_pkg.sv
// Shared types and constants for the mux BIST sequencer: FSM encoding, base patterns, vector count.
// Pure declarations, so there is no latency and no backpressure.
package mux_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } pat_t;

    localparam int NUM_PAT = 4;
    localparam int NUM_SEL = 3;
    localparam int NUM_VEC = NUM_PAT * NUM_SEL;

    localparam logic [31:0] PAT_ZERO = 32'h0000_0000;
    localparam logic [31:0] PAT_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] PAT_AA   = 32'hAAAA_AAAA;
    localparam logic [31:0] PAT_55   = 32'h5555_5555;

    function automatic logic [31:0] base_pat(input logic [1:0] p);
        logic [31:0] r;
        case (p)
            2'd0:    r = PAT_ZERO;
            2'd1:    r = PAT_ONES;
            2'd2:    r = PAT_AA;
            default: r = PAT_55;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mux_bist_patgen.sv
// Combinational (p,sel) -> {pat_a,pat_b,pat_c} stimulus generator for the mux checkers.
// Zero latency, no backpressure; drives all-zero whenever the sequencer is not applying a vector.
module mux_bist_patgen
    import mux_bist_pkg::*;
#(
    parameter logic [31:0] C_MASK = 32'h0F0F_0F0F
) (
    input  logic       en,
    input  logic [1:0] p,
    input  logic [1:0] sel,
    output pat_t       pats
);

    logic [31:0] base;

    always_comb begin
        base = base_pat(p);
        pats = '0;
        // sel=3 has no mux input behind it, so it never produces stimulus
        if (en && (sel != 2'd3)) begin
            pats.a = base;
            pats.b = ~base;
            pats.c = base ^ C_MASK;
        end
    end

endmodule

// File: rtl/mux_bist_seq.sv
// BIST sequencer: 12 vectors (4 patterns x sel 0..2), one drain cycle, one report cycle.
// start-to-done is 14 cycles; start is ignored while busy, there is no other backpressure.
module mux_bist_seq
    import mux_bist_pkg::*;
#(
    parameter logic [31:0] C_MASK = 32'h0F0F_0F0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mux2_fault,
    input  logic        mux3_fault,
    output logic        test_en,
    output logic [1:0]  sel,
    output logic        s2,
    output logic [31:0] pat_a,
    output logic [31:0] pat_b,
    output logic [31:0] pat_c,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_mask
);

    localparam logic [3:0] LAST_VEC = 4'(NUM_VEC - 1);

    state_t     state;
    logic [1:0] p;
    logic [3:0] vec_cnt;
    pat_t       pats;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            p         <= 2'd0;
            sel       <= 2'd0;
            vec_cnt   <= 4'd0;
            test_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_APPLY;
                        p       <= 2'd0;
                        sel     <= 2'd0;
                        vec_cnt <= 4'd0;
                        test_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    vec_cnt <= vec_cnt + 4'd1;
                    if (vec_cnt == LAST_VEC) begin
                        state   <= ST_DRAIN;
                        test_en <= 1'b0;
                        p       <= 2'd0;
                        sel     <= 2'd0;
                    end else if (sel == 2'd2) begin
                        sel <= 2'd0;
                        p   <= p + 2'd1;
                    end else begin
                        sel <= sel + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    // flags from the last vector are registered by now; capture so REPORT shows them
                    state     <= ST_REPORT;
                    done      <= 1'b1;
                    fail_mask <= {mux3_fault, mux2_fault};
                    pass      <= ~|{mux3_fault, mux2_fault};
                end
                ST_REPORT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mux_bist_patgen #(
        .C_MASK(C_MASK)
    ) u_patgen (
        .en   (test_en),
        .p    (p),
        .sel  (sel),
        .pats (pats)
    );

    assign pat_a = pats.a;
    assign pat_b = pats.b;
    assign pat_c = pats.c;
    assign s2    = sel[0];

    a_sel_legal: assert property (@(posedge clk) disable iff (!rst) sel != 2'd3);
    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst)
        (state == ST_IDLE || state == ST_DRAIN) |-> (!test_en && sel == 2'd0));
    a_done_in_report: assert property (@(posedge clk) disable iff (!rst)
        done |-> (state == ST_REPORT && busy));

endmodule
